lfsr_seq_gen: RTL and testbench
===============================

// Module: lfsr_seq_gen
// PURPOSE
//  Parametrised LFSR sequence generator. On start, fills an internal DEPTH-entry RAM
//  with DEPTH consecutive LFSR samples (one write per clock), pulses finish, returns idle.
//  Seed is loadable at run time. Writes are mirrored on a write port for downstream RAMs.
//  A registered read port exposes stored samples to consumers.
// PARAMETERS
//  LFSR_W   16        LFSR state width (>=4)
//  DATA_W   4         stored sample width = LFSR state[DATA_W-1:0] (DATA_W<=LFSR_W)
//  DEPTH    32        entries per run (power of two, >=2)
//  ADDR_W   $clog2(DEPTH)  address width
//  TAPS     16'hB400  feedback tap mask (bit i set => state[i] feeds back)
//  SEED     16'hBEEF  reset/default LFSR state (must be nonzero)
// PORTS
//  clk         in   1        clock
//  rst         in   1        reset, synchronous, active-low
//  start       in   1        begin a run; sampled only in IDLE
//  seed_valid  in   1        load seed into LFSR; sampled only in IDLE
//  seed        in   LFSR_W   seed value
//  busy        out  1        high in RUN and DONE
//  finish      out  1        one-cycle pulse when a run completes
//  wr_en       out  1        high while a sample is being written
//  wr_addr     out  ADDR_W   address of current write
//  wr_data     out  DATA_W   sample being written
//  rd_addr     in   ADDR_W   readback address
//  rd_data     out  DATA_W   ram[rd_addr], registered, 1-cycle latency
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE, lfsr=SEED, addr=0, finish=0, rd_data=0.
//    busy/wr_en=0. RAM contents not cleared. Reset mid-run aborts run; no finish pulse.
//  - LFSR step: next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)} (Fibonacci, left shift).
//    LFSR advances only on RUN cycles; holds otherwise. Not re-seeded between runs.
//  - FSM: IDLE -> RUN on start. RUN -> DONE when addr==DEPTH-1. DONE -> IDLE always.
//  - IDLE: seed_valid=1 loads lfsr<=seed. seed_valid and start in same cycle: seed
//    loads and run starts; first write uses the new seed.
//  - RUN (each cycle): wr_en=1, wr_addr=addr, wr_data=lfsr[DATA_W-1:0]; at edge
//    ram[addr]<=wr_data, lfsr<=next, addr<=addr+1 (wraps to 0 after DEPTH-1).
//  - DONE: finish=1 for exactly this cycle; addr<=0.
//  - Timing: start seen at edge E0 -> writes in cycles E0+1..E0+DEPTH. finish high in
//    cycle E0+DEPTH+1. IDLE from E0+DEPTH+2; back-to-back start accepted there.
//  - start or seed_valid during RUN/DONE: ignored, no effect.
//  - wr_en/wr_addr/wr_data/busy/finish decoded from registered state only; no
//    combinational path from inputs.
//  - Read port: rd_data<=ram[rd_addr] every cycle. Read and write to the same address
//    in the same cycle return the old data.
// CONFIGURATION
//  LFSR_ZERO_GUARD_EN defined: seed load of all-zero loads SEED instead. Any lfsr==0
//    reaching RUN is replaced by SEED before the step. Lock-up is impossible.
//  Not defined: seed load of 0 is accepted. LFSR stays 0; every run writes DATA_W'd0.
// TESTING
//  1 Reset, start pulse -> writes ram[0..2]=F,E,D (lfsr BEEF,7DDE,FBBD). 32 writes total.
//    finish high exactly at cycle 33 after start edge. busy low at cycle 34.
//  2 Readback after run: rd_addr=1 -> rd_data=4'hE next cycle. rd_addr=31 -> ram[31]
//    matches reference model.
//  3 seed_valid+start same cycle, seed=16'h0001 -> first wr_data=1, second=2
//    (lfsr 0002). Ignored seed_valid mid-run leaves sequence unchanged.
//  4 start held high continuously -> runs back-to-back, one idle cycle between finish
//    and next wr_en. Second run continues LFSR sequence from end of first.
//  5 rst low at 10th RUN cycle -> busy=0, no finish, next run restarts at addr 0
//    from SEED.
//  6 seed=0 loaded: with LFSR_ZERO_GUARD_EN first wr_data=F; without it all 32
//    writes =0.

Source files
------------

// File: rtl/lfsr_seq_gen.sv
// LFSR sequence generator: fills a DEPTH-entry RAM with consecutive LFSR samples per run.
// Optional LFSR_ZERO_GUARD_EN: an all-zero seed or state is replaced by SEED (no lock-up).
module lfsr_seq_gen #(
  parameter int unsigned             LFSR_W = 16,
  parameter int unsigned             DATA_W = 4,
  parameter int unsigned             DEPTH  = 32,
  parameter int unsigned             ADDR_W = $clog2(DEPTH),
  parameter logic [LFSR_W-1:0]       TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0]       SEED   = 16'hBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  output logic              finish,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [LFSR_W-1:0]   lfsr_cur;
  logic [LFSR_W-1:0]   lfsr_next;
  logic [LFSR_W-1:0]   seed_eff;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef LFSR_ZERO_GUARD_EN
  assign lfsr_cur = (lfsr_q == '0) ? SEED : lfsr_q;
  assign seed_eff = (seed == '0) ? SEED : seed;
`else
  assign lfsr_cur = lfsr_q;
  assign seed_eff = seed;
`endif

  assign lfsr_next = {lfsr_cur[LFSR_W-2:0], ^(lfsr_cur & TAPS)};

  // All outputs decode from registered state only, so inputs never reach them combinationally.
  assign busy    = (state_q != IDLE);
  assign finish  = (state_q == DONE);
  assign wr_en   = (state_q == RUN);
  assign wr_addr = addr_q;
  assign wr_data = lfsr_cur[DATA_W-1:0];
  assign rd_data = rd_data_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (seed_valid) lfsr_d = seed_eff;
        if (start)      state_d = RUN;
      end
      RUN: begin
        lfsr_d = lfsr_next;
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) state_d = DONE;
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      addr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      addr_q    <= addr_d;
      rd_data_q <= mem[rd_addr];
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped along with the aborted run.
  always_ff @(posedge clk) begin
    if (rst && state_q == RUN) mem[addr_q] <= wr_data;
  end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Scoreboard bench for lfsr_seq_gen: expected writes are queued, a negedge monitor checks them.
module tb_lfsr_seq_gen;
  localparam int DEPTH = 32;
  localparam logic [15:0] SEED_V = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        seed_valid = 1'b0;
  logic [15:0] seed = '0;
  logic        busy, finish, wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [4:0]  rd_addr = '0;
  logic [3:0]  rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] a;
    logic [3:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [3:0]  ref_mem [DEPTH];
  logic [15:0] m;

  lfsr_seq_gen #(
    .LFSR_W(16), .DATA_W(4), .DEPTH(32), .ADDR_W(5),
    .TAPS(16'hB400), .SEED(16'hBEEF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed_valid(seed_valid), .seed(seed),
    .busy(busy), .finish(finish), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Queue n expected writes starting at address 0, advancing the model state m.
  task automatic push_n(input int n);
    for (int a = 0; a < n; a++) begin
      logic [15:0] v;
      wr_t e;
      v = m;
`ifdef LFSR_ZERO_GUARD_EN
      if (v == 16'h0000) v = SEED_V;
`endif
      e.a = a[4:0];
      e.d = v[3:0];
      exp_q.push_back(e);
      ref_mem[a] = v[3:0];
      m = step(v);
    end
  endtask

  task automatic wait_finish(output int fcyc);
    fcyc = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (finish) begin
        fcyc = k;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
        chk("wr_data", {28'd0, wr_data}, {28'd0, e.d});
      end
    end
  end

  initial begin
    int nw, fcyc, f1, f2, nf;
    logic [3:0] hand [3];
    hand[0] = 4'hF; hand[1] = 4'hE; hand[2] = 4'hD;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_rd_data", {28'd0, rd_data}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Test 1: default seed run, exact timing
    m = SEED_V;
    push_n(DEPTH);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nw = 0; fcyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wr_en) nw++;
      if (k <= 3) chk("t1_first_data", {28'd0, wr_data}, {28'd0, hand[k-1]});
      if (finish && fcyc == 0) fcyc = k;
      if (k == 34) chk("t1_busy_low", {31'd0, busy}, 32'd0);
    end
    chk("t1_writes", nw, 32);
    chk("t1_finish_cycle", fcyc, 33);
    chk("t1_drained", exp_q.size(), 0);

    // Test 2: readback
    rd_addr = 5'd1;
    @(negedge clk);
    chk("t2_rd1", {28'd0, rd_data}, 32'hE);
    rd_addr = 5'd31;
    @(negedge clk);
    chk("t2_rd31", {28'd0, rd_data}, {28'd0, ref_mem[31]});

    // Test 3: seed+start together, ignored seed_valid/start mid-run
    m = 16'h0001;
    push_n(DEPTH);
    seed = 16'h0001; seed_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1 begin start = 1'b0; seed_valid = 1'b0; end
    fcyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("t3_first", {28'd0, wr_data}, 32'h1);
      if (k == 2) chk("t3_second", {28'd0, wr_data}, 32'h2);
      if (k == 5) begin seed = 16'hFFFF; seed_valid = 1'b1; start = 1'b1; end
      if (k == 6) begin seed_valid = 1'b0; start = 1'b0; end
      if (finish && fcyc == 0) fcyc = k;
    end
    chk("t3_finish_cycle", fcyc, 33);
    chk("t3_drained", exp_q.size(), 0);

    // Test 4: start held high, back-to-back runs continue the sequence
    push_n(DEPTH);
    push_n(DEPTH);
    start = 1'b1;
    f1 = 0; f2 = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 34) chk("t4_gap_idle", {31'd0, wr_en}, 32'd0);
      if (k == 35) chk("t4_restart", {31'd0, wr_en}, 32'd1);
      if (finish) begin
        if (f1 == 0) f1 = k;
        else begin
          f2 = k;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("t4_finish1", f1, 33);
    chk("t4_finish2", f2, 67);
    repeat (3) @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);

    // Test 5: reset at 10th RUN cycle aborts, next run restarts from SEED at addr 0
    push_n(10);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_wr_en", {31'd0, wr_en}, 32'd0);
    rst = 1'b1;
    nf = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (finish) nf++;
    end
    chk("t5_no_finish", nf, 0);
    chk("t5_drained_abort", exp_q.size(), 0);
    m = SEED_V;
    push_n(DEPTH);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_finish(fcyc);
    chk("t5_finish_cycle", fcyc, 33);
    chk("t5_drained", exp_q.size(), 0);

    // Test 6: zero seed
    @(negedge clk);
    m = 16'h0000;
    push_n(DEPTH);
    seed = 16'h0000; seed_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1 begin start = 1'b0; seed_valid = 1'b0; end
    @(negedge clk);
`ifdef LFSR_ZERO_GUARD_EN
    chk("t6_first", {28'd0, wr_data}, 32'hF);
`else
    chk("t6_first", {28'd0, wr_data}, 32'h0);
`endif
    wait_finish(fcyc);
    chk("t6_finish_cycle", fcyc, 32);
    chk("t6_drained", exp_q.size(), 0);
    rd_addr = 5'd17;
    @(negedge clk);
    chk("t6_rd17", {28'd0, rd_data}, {28'd0, ref_mem[17]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
